// File: rtl/pmem_arbiter.sv
// Physical-memory arbiter: shares one line-wide memory port between the
// instruction cache and the data cache. Each grant latches a registered
// transaction. The response is steered to the owning cache only. A single
// turnaround cycle follows every transaction, so the caches can update their
// tag/valid/dirty state before any new request is sampled.
module pmem_arbiter #(
  parameter int unsigned ADDR_WIDTH  = 32,
  parameter int unsigned LINE_WIDTH  = 256,
  parameter int unsigned OFFSET_BITS = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  // icache side
  input  logic [ADDR_WIDTH-1:0] i_pmem_address,
  input  logic                  i_pmem_read,
  output logic [LINE_WIDTH-1:0] i_pmem_rdata,
  output logic                  i_pmem_resp,
  // dcache side
  input  logic [ADDR_WIDTH-1:0] d_pmem_address,
  input  logic                  d_pmem_read,
  input  logic                  d_pmem_write,
  input  logic [LINE_WIDTH-1:0] d_pmem_wdata,
  output logic [LINE_WIDTH-1:0] d_pmem_rdata,
  output logic                  d_pmem_resp,
  // memory side
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic                  mem_read,
  output logic                  mem_write,
  output logic [LINE_WIDTH-1:0] mem_wdata,
  input  logic [LINE_WIDTH-1:0] mem_rdata,
  input  logic                  mem_resp
);

  typedef enum logic [1:0] {StIdle, StServeI, StServeD, StTurn} state_e;

  localparam logic [ADDR_WIDTH-1:0] AlignMask = {ADDR_WIDTH{1'b1}} << OFFSET_BITS;

  state_e                state_q, state_d;
  logic                  last_d_q, last_d_d;  // 1: dcache was granted last
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [LINE_WIDTH-1:0] wdata_q, wdata_d;
  logic                  read_q, read_d;
  logic                  write_q, write_d;

  logic i_req, d_req, grant_i, grant_d;

  assign i_req = i_pmem_read;
  assign d_req = d_pmem_read | d_pmem_write;

  // dcache wins a tie unless it was served last; grants alternate under load.
  assign grant_d = d_req & (~i_req | ~last_d_q);
  assign grant_i = i_req & (~d_req | last_d_q);

  // Read data is a plain passthrough; only the resp strobe qualifies it.
  assign i_pmem_rdata = mem_rdata;
  assign d_pmem_rdata = mem_rdata;

  assign mem_address = addr_q;
  assign mem_wdata   = wdata_q;
  assign mem_read    = read_q;
  assign mem_write   = write_q;

  // Next-state, transaction latch and combinational response steering.
  always_comb begin
    state_d     = state_q;
    last_d_d    = last_d_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    read_d      = read_q;
    write_d     = write_q;
    i_pmem_resp = 1'b0;
    d_pmem_resp = 1'b0;
    case (state_q)
      StIdle: begin
        if (grant_d) begin
          state_d  = StServeD;
          last_d_d = 1'b1;
          addr_d   = d_pmem_address & AlignMask;
          wdata_d  = d_pmem_wdata;
          // A writeback takes priority if both strobes are raised.
          write_d  = d_pmem_write;
          read_d   = ~d_pmem_write;
        end else if (grant_i) begin
          state_d  = StServeI;
          last_d_d = 1'b0;
          addr_d   = i_pmem_address & AlignMask;
          read_d   = 1'b1;
          write_d  = 1'b0;
        end
      end
      StServeI: begin
        if (mem_resp) begin
          i_pmem_resp = 1'b1;
          state_d     = StTurn;
          read_d      = 1'b0;
          write_d     = 1'b0;
        end
      end
      StServeD: begin
        if (mem_resp) begin
          d_pmem_resp = 1'b1;
          state_d     = StTurn;
          read_d      = 1'b0;
          write_d     = 1'b0;
        end
      end
      StTurn: begin
        // mem_resp and client requests are deliberately ignored here.
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // State and transaction registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      last_d_q <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      read_q   <= 1'b0;
      write_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      last_d_q <= last_d_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      read_q   <= read_d;
      write_q  <= write_d;
    end
  end

endmodule

// File: tb/tb_pmem_arbiter.sv
// Randomized scoreboard bench for pmem_arbiter. Two client drivers issue
// requests and push the memory operation each expects. A memory model answers
// with random latency. A negedge monitor predicts grant owner and start cycle
// from the arbitration rules, then checks each response against the owner's
// queue.
module tb_pmem_arbiter;

  localparam int AW = 32;
  localparam int LW = 256;
  localparam logic [AW-1:0] AlignMask = 32'hFFFF_FFE0;

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] i_pmem_address, d_pmem_address, mem_address;
  logic          i_pmem_read, i_pmem_resp, d_pmem_read, d_pmem_write, d_pmem_resp;
  logic [LW-1:0] i_pmem_rdata, d_pmem_rdata, d_pmem_wdata, mem_wdata, mem_rdata;
  logic          mem_read, mem_write, mem_resp;

  pmem_arbiter #(.ADDR_WIDTH(AW), .LINE_WIDTH(LW), .OFFSET_BITS(5)) dut (
    .clk(clk), .rst(rst),
    .i_pmem_address(i_pmem_address), .i_pmem_read(i_pmem_read),
    .i_pmem_rdata(i_pmem_rdata), .i_pmem_resp(i_pmem_resp),
    .d_pmem_address(d_pmem_address), .d_pmem_read(d_pmem_read),
    .d_pmem_write(d_pmem_write), .d_pmem_wdata(d_pmem_wdata),
    .d_pmem_rdata(d_pmem_rdata), .d_pmem_resp(d_pmem_resp),
    .mem_address(mem_address), .mem_read(mem_read), .mem_write(mem_write),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_resp(mem_resp)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0] addr;
    logic          rd;
    logic          wr;
    logic [LW-1:0] wdata;
  } op_t;

  op_t exp_q_i[$];
  op_t exp_q_d[$];

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  // Model / handshake state shared between processes.
  bit  mon_en = 0, auto_mem = 0;
  bit  i_pend = 0, d_pend = 0;
  int  i_raise = 0, d_raise = 0;
  int  last_resp = 0;
  bit  last_was_d = 0;
  bit  busy = 0, cur_owner_d = 0, resp_real = 0, resp_owner_d = 0, spur_next = 0;
  int  cnt = 0;
  op_t cur_op;

  // Monitor scratch.
  op_t e;
  bit  ip, dp;
  int  earliest, exp_start;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [LW-1:0] rand_line();
    logic [LW-1:0] v;
    for (int k = 0; k < LW / 32; k++) v[k*32 +: 32] = $urandom;
    return v;
  endfunction

  // Memory model: answers each started transaction after 1..4 cycles and
  // sometimes throws a stray mem_resp into the following turnaround cycle.
  initial begin
    mem_resp  = 1'b0;
    mem_rdata = '0;
    forever begin
      @(posedge clk);
      #1;
      if (auto_mem) begin
        mem_resp  = 1'b0;
        resp_real = 1'b0;
        if (busy) begin
          if (cnt == 0) begin
            mem_resp     = 1'b1;
            resp_real    = 1'b1;
            resp_owner_d = cur_owner_d;
            mem_rdata    = rand_line();
            busy         = 1'b0;
            spur_next    = ($urandom_range(0, 1) == 1);
          end else begin
            cnt--;
          end
        end else if (spur_next) begin
          mem_resp  = 1'b1;
          mem_rdata = rand_line();
          spur_next = 1'b0;
        end
      end
    end
  end

  // Monitor: response steering, op scoreboard, grant owner and start timing.
  always @(negedge clk) begin
    if (mon_en) begin
      check("i_resp", i_pmem_resp, resp_real && !resp_owner_d);
      check("d_resp", d_pmem_resp, resp_real && resp_owner_d);
      if (resp_real) begin
        if (resp_owner_d ? (exp_q_d.size() == 0) : (exp_q_i.size() == 0)) begin
          checks++;
          failures++;
          $display("FAIL scoreboard_empty: resp with no expected op (owner_d=%0d)", resp_owner_d);
        end else begin
          e = resp_owner_d ? exp_q_d.pop_front() : exp_q_i.pop_front();
          check("op_addr", cur_op.addr, e.addr);
          check("op_read", cur_op.rd, e.rd);
          check("op_write", cur_op.wr, e.wr);
          if (e.wr) check("op_wdata", cur_op.wdata, e.wdata);
          check("addr_stable", mem_address, e.addr);
          check("rdata_pass", resp_owner_d ? d_pmem_rdata : i_pmem_rdata, mem_rdata);
        end
        last_resp = cyc;
      end
      if (auto_mem && !busy && !mem_resp && (mem_read || mem_write)) begin
        ip = i_pend && (i_raise < cyc);
        dp = d_pend && (d_raise < cyc);
        if (!ip && !dp) begin
          checks++;
          failures++;
          $display("FAIL spurious_req: memory request at cycle %0d with none pending", cyc);
        end else begin
          cur_owner_d = dp && (!ip || !last_was_d);
          earliest    = (ip && dp) ? ((i_raise < d_raise) ? i_raise : d_raise)
                                   : (ip ? i_raise : d_raise);
          exp_start   = (earliest + 1 > last_resp + 3) ? earliest + 1 : last_resp + 3;
          check("start_cycle", cyc, exp_start);
          last_was_d  = cur_owner_d;
        end
        cur_op = '{mem_address, mem_read, mem_write, mem_wdata};
        busy   = 1'b1;
        cnt    = $urandom_range(0, 3);
      end
    end
  end

  task automatic drive_i(input int n);
    for (int k = 0; k < n; k++) begin
      int gap = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0;
      int t = 0;
      logic [AW-1:0] a;
      repeat (gap) begin @(posedge clk); #1; end
      a = $urandom;
      exp_q_i.push_back('{a & AlignMask, 1'b1, 1'b0, '0});
      i_pmem_address = a;
      i_pmem_read    = 1'b1;
      i_raise        = cyc;
      i_pend         = 1'b1;
      do begin @(negedge clk); t++; end while (!i_pmem_resp && t < 200);
      if (!i_pmem_resp) begin
        checks++;
        failures++;
        $display("FAIL i_timeout: no i_pmem_resp within 200 cycles");
        i_pmem_read = 1'b0;
        return;
      end
      i_pend = 1'b0;
      @(posedge clk); #1;
      // Sometimes keep the request up through the turnaround cycle.
      if ($urandom_range(0, 2) == 0) begin @(posedge clk); #1; end
      i_pmem_read = 1'b0;
    end
  endtask

  task automatic drive_d(input int n);
    for (int k = 0; k < n; k++) begin
      int gap = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0;
      int t = 0;
      int kind = $urandom_range(0, 3);
      logic [AW-1:0] a;
      logic [LW-1:0] w;
      repeat (gap) begin @(posedge clk); #1; end
      a = $urandom;
      w = rand_line();
      exp_q_d.push_back('{a & AlignMask, kind < 2, kind >= 2, w});
      d_pmem_address = a;
      d_pmem_wdata   = w;
      d_pmem_read    = (kind != 2);
      d_pmem_write   = (kind >= 2);
      d_raise        = cyc;
      d_pend         = 1'b1;
      do begin @(negedge clk); t++; end while (!d_pmem_resp && t < 200);
      if (!d_pmem_resp) begin
        checks++;
        failures++;
        $display("FAIL d_timeout: no d_pmem_resp within 200 cycles");
        d_pmem_read  = 1'b0;
        d_pmem_write = 1'b0;
        return;
      end
      d_pend = 1'b0;
      @(posedge clk); #1;
      if ($urandom_range(0, 2) == 0) begin @(posedge clk); #1; end
      d_pmem_read  = 1'b0;
      d_pmem_write = 1'b0;
    end
  endtask

  initial begin
    logic [LW-1:0] wd;
    logic [LW-1:0] a5;
    a5 = {32{8'hA5}};
    rst = 1'b1;
    i_pmem_address = '0; i_pmem_read = 1'b0;
    d_pmem_address = '0; d_pmem_read = 1'b0; d_pmem_write = 1'b0; d_pmem_wdata = '0;
    repeat (3) @(posedge clk);
    #1;
    rst       = 1'b0;
    last_resp = cyc - 2;  // IDLE from the last reset edge onward
    @(negedge clk);
    check("rst_mem_read", mem_read, 1'b0);
    check("rst_mem_write", mem_write, 1'b0);
    check("rst_mem_address", mem_address, '0);
    check("rst_mem_wdata", mem_wdata, '0);
    check("rst_i_resp", i_pmem_resp, 1'b0);
    check("rst_d_resp", d_pmem_resp, 1'b0);
    @(posedge clk); #1;
    mon_en   = 1'b1;
    auto_mem = 1'b1;

    fork
      drive_i(40);
      drive_d(40);
    join
    repeat (4) begin @(posedge clk); #1; end
    check("queue_i_drained", exp_q_i.size(), 0);
    check("queue_d_drained", exp_q_d.size(), 0);
    mon_en   = 1'b0;
    auto_mem = 1'b0;
    mem_resp = 1'b0;

    // Reset in the middle of a dcache writeback; a late mem_resp is dropped.
    wd = rand_line();
    d_pmem_address = 32'h0000_3FFF;
    d_pmem_wdata   = wd;
    d_pmem_write   = 1'b1;
    @(posedge clk); #1;
    check("wb_mem_write", mem_write, 1'b1);
    check("wb_mem_read", mem_read, 1'b0);
    check("wb_mem_address", mem_address, 32'h0000_3FE0);
    check("wb_mem_wdata", mem_wdata, wd);
    rst          = 1'b1;
    d_pmem_write = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    check("midrst_mem_write", mem_write, 1'b0);
    check("midrst_mem_address", mem_address, '0);
    check("midrst_mem_wdata", mem_wdata, '0);
    @(posedge clk); #1;
    mem_resp = 1'b1;
    @(negedge clk);
    check("late_resp_d", d_pmem_resp, 1'b0);
    check("late_resp_i", i_pmem_resp, 1'b0);
    @(posedge clk); #1;
    mem_resp = 1'b0;
    check("late_resp_no_req", mem_read | mem_write, 1'b0);

    // Icache-only read with the 0xA5 pattern; request held into TURN.
    i_pmem_address = 32'h0000_1044;
    i_pmem_read    = 1'b1;
    @(posedge clk); #1;
    check("i_mem_read", mem_read, 1'b1);
    check("i_mem_address", mem_address, 32'h0000_1040);
    mem_resp  = 1'b1;
    mem_rdata = a5;
    @(negedge clk);
    check("i_resp_pulse", i_pmem_resp, 1'b1);
    check("i_rdata", i_pmem_rdata, a5);
    check("i_no_d_resp", d_pmem_resp, 1'b0);
    @(posedge clk); #1;
    mem_resp = 1'b1;  // stray response in TURN must be ignored
    @(negedge clk);
    check("turn_no_req", mem_read | mem_write, 1'b0);
    check("turn_no_resp", i_pmem_resp | d_pmem_resp, 1'b0);
    @(posedge clk); #1;
    mem_resp    = 1'b0;
    i_pmem_read = 1'b0;
    @(posedge clk); #1;
    check("held_no_regrant", mem_read | mem_write, 1'b0);

    // Simultaneous requests after an icache grant: dcache first, then icache.
    i_pmem_address = 32'h0000_0100; i_pmem_read = 1'b1;
    d_pmem_address = 32'h0000_0200; d_pmem_read = 1'b1;
    @(posedge clk); #1;
    check("both_first_addr", mem_address, 32'h0000_0200);
    mem_resp = 1'b1;
    @(negedge clk);
    check("both_first_d_resp", d_pmem_resp, 1'b1);
    check("both_first_i_resp", i_pmem_resp, 1'b0);
    @(posedge clk); #1;
    mem_resp    = 1'b0;
    d_pmem_read = 1'b0;
    @(posedge clk); #1;
    check("both_gap", mem_read, 1'b0);
    @(posedge clk); #1;
    check("both_second_addr", mem_address, 32'h0000_0100);
    check("both_second_read", mem_read, 1'b1);
    mem_resp = 1'b1;
    @(negedge clk);
    check("both_second_i_resp", i_pmem_resp, 1'b1);
    @(posedge clk); #1;
    mem_resp    = 1'b0;
    i_pmem_read = 1'b0;
    repeat (2) @(posedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    failures++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

endmodule
